// File: rtl/console_chk_pkg.sv
// Shared types and constants for the console token checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package console_chk_pkg;

  // Longest token the config storage can hold; the top MAX_TOK_LEN must not exceed it.
  localparam int TOK_LEN_LIMIT = 16;
  localparam int TOK_POS_W     = $clog2(TOK_LEN_LIMIT);
  localparam int TOK_LEN_W     = $clog2(TOK_LEN_LIMIT + 1);

  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam int         PCT_SCALE = 100;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_COMMIT,
    ST_FLUSH,
    ST_VERDICT,
    ST_DONE
  } chk_state_t;

  // One programmable token: chars[0] is the first character of the token.
  typedef struct packed {
    logic [TOK_LEN_LIMIT-1:0][7:0] chars;
    logic [TOK_LEN_W-1:0]          len;
    logic                          is_pass;
  } tok_cfg_t;

endpackage

// File: rtl/console_tok_match.sv
// Compares one token against the tail of the line history window.
// Latency: combinational.
// Backpressure: none; evaluated on every cycle.
module console_tok_match
  import console_chk_pkg::*;
(
  input  tok_cfg_t                      tok,
  input  logic [TOK_LEN_LIMIT-1:0][7:0] win,   // win[0] is the newest byte
  input  logic [TOK_LEN_W-1:0]          fill,  // valid bytes in win
  output logic                          match
);

  // Class is resolved by the caller at line commit.
  logic unused_cls;
  assign unused_cls = tok.is_pass;

  // Newest byte lines up with the last token character; a disabled or not yet
  // fully seen token never matches.
  always_comb begin
    match = (tok.len != '0) && (fill >= tok.len);
    for (int k = 0; k < TOK_LEN_LIMIT; k++) begin
      if (k < int'(tok.len)) begin
        if (win[k] != tok.chars[TOK_POS_W'(tok.len - TOK_LEN_W'(k + 1))]) begin
          match = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/console_token_checker.sv
// Line-by-line token matcher on the console byte stream with pass/fail counts and a threshold verdict.
// Latency: hit visible 1 cycle after a byte, counter 2 cycles after LF, verdict 3 edges after end_i.
// Backpressure: s_ready drops for one cycle per LF and permanently once the test has ended.
// Optional watchdog enabled by defining CONSOLE_CHK_TIMEOUT_EN.
module console_token_checker
  import console_chk_pkg::*;
#(
  parameter int NUM_TOKENS     = 2,
  parameter int MAX_TOK_LEN    = 16,   // must not exceed TOK_LEN_LIMIT
  parameter int CNT_W          = 16,
  parameter int PASS_PCT       = 99,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  input  logic [7:0]                       s_data,
  output logic                             s_ready,
  input  logic                             cfg_we,
  input  logic [$clog2(NUM_TOKENS)-1:0]    cfg_idx,
  input  logic [$clog2(MAX_TOK_LEN)-1:0]   cfg_pos,
  input  logic [7:0]                       cfg_char,
  input  logic                             cfg_len_we,
  input  logic [$clog2(MAX_TOK_LEN+1)-1:0] cfg_len,
  input  logic                             cfg_is_pass,
  input  logic                             end_i,
  output logic [CNT_W-1:0]                 pass_cnt,
  output logic [CNT_W-1:0]                 fail_cnt,
  output logic                             done,
  output logic                             verdict_pass,
  output logic                             timeout
);

  localparam int VW = CNT_W + 8;

  chk_state_t                    state, state_nxt;
  tok_cfg_t                      toks [NUM_TOKENS];
  logic [TOK_LEN_LIMIT-2:0][7:0] win;
  logic [TOK_LEN_LIMIT-1:0][7:0] win_nxt;
  logic [TOK_LEN_W-1:0]          fill, fill_nxt;
  logic [NUM_TOKENS-1:0]         tok_hit, line_hit;
  logic                          accept, is_lf, end_pend, end_req, commit_en;
  logic                          hit_any, hit_pass, timeout_fire, verdict_calc;
  logic [CNT_W:0]                tests;
  logic [VW-1:0]                 pass_scaled, tests_scaled;

  assign s_ready   = (state == ST_RUN);
  assign accept    = s_valid && s_ready;
  assign is_lf     = (s_data == ASCII_LF);
  assign end_req   = end_i || end_pend;
  assign commit_en = (state == ST_COMMIT) || (state == ST_FLUSH);

  // Window as it will look once the incoming byte is stored, so a hit is
  // recorded on the same edge that accepts the byte.
  assign win_nxt  = {win, s_data};
  assign fill_nxt = (32'(fill) < MAX_TOK_LEN) ? fill + 1'b1 : fill;

  for (genvar i = 0; i < NUM_TOKENS; i++) begin : g_tok
    console_tok_match u_match (
      .tok   (toks[i]),
      .win   (win_nxt),
      .fill  (fill_nxt),
      .match (tok_hit[i])
    );
  end

  // Token programming; an over-long length clamps to the window depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TOKENS; i++) toks[i] <= '0;
    end else begin
      if (cfg_we && (32'(cfg_idx) < NUM_TOKENS)) begin
        toks[cfg_idx].chars[TOK_POS_W'(cfg_pos)] <= cfg_char;
      end
      if (cfg_len_we && (32'(cfg_idx) < NUM_TOKENS)) begin
        toks[cfg_idx].len     <= (32'(cfg_len) > MAX_TOK_LEN) ? TOK_LEN_W'(MAX_TOK_LEN)
                                                              : TOK_LEN_W'(cfg_len);
        toks[cfg_idx].is_pass <= cfg_is_pass;
      end
    end
  end

  // Line history and sticky per-token hits; LF is never stored and wipes the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win      <= '0;
      fill     <= '0;
      line_hit <= '0;
    end else if (commit_en) begin
      win      <= '0;
      fill     <= '0;
      line_hit <= '0;
    end else if (accept) begin
      if (is_lf) begin
        win  <= '0;
        fill <= '0;
      end else begin
        win      <= win_nxt[TOK_LEN_LIMIT-2:0];
        fill     <= fill_nxt;
        line_hit <= line_hit | tok_hit;
      end
    end
  end

  // Lowest-index hit decides the class of the line.
  always_comb begin
    hit_any  = 1'b0;
    hit_pass = 1'b0;
    for (int i = NUM_TOKENS - 1; i >= 0; i--) begin
      if (line_hit[i]) begin
        hit_any  = 1'b1;
        hit_pass = toks[i].is_pass;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next-state: end of test (or watchdog) wins over a same-cycle LF since FLUSH commits the line anyway.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (timeout_fire || end_req)  state_nxt = ST_FLUSH;
        else if (accept && is_lf)     state_nxt = ST_COMMIT;
      end
      ST_COMMIT:  state_nxt = ST_RUN;
      ST_FLUSH:   state_nxt = ST_VERDICT;
      ST_VERDICT: state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_DONE;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // An end request seen during COMMIT is held until the FSM is back in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              end_pend <= 1'b0;
    else if ((state == ST_COMMIT) && end_i)  end_pend <= 1'b1;
    else if (state == ST_RUN)                end_pend <= 1'b0;
  end

  // Saturating per-class line counters, at most one step per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (commit_en && hit_any) begin
      if (hit_pass) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

  assign tests        = {1'b0, pass_cnt} + {1'b0, fail_cnt};
  assign pass_scaled  = VW'(pass_cnt) * VW'(PCT_SCALE);
  assign tests_scaled = VW'(tests) * VW'(PASS_PCT);
  assign verdict_calc = (tests != '0) && (pass_scaled > tests_scaled);

  // Verdict is captured once and held until reset; a watchdog expiry always fails.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done         <= 1'b0;
      verdict_pass <= 1'b0;
    end else if (state == ST_VERDICT) begin
      done         <= 1'b1;
      verdict_pass <= verdict_calc && !timeout;
    end
  end

`ifdef CONSOLE_CHK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog;
  logic            timeout_q;

  assign timeout_fire = (state == ST_RUN) && !accept && (32'(wdog) == TIMEOUT_CYCLES - 1);
  assign timeout      = timeout_q;

  // Idle-cycle watchdog: counts RUN cycles without an accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else if (state == ST_RUN) begin
      if (accept)            wdog      <= '0;
      else if (timeout_fire) timeout_q <= 1'b1;
      else                   wdog      <= wdog + 1'b1;
    end
  end
`else
  // Watchdog limit has no function in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_fire       = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule
